// File: rtl/color_det_pkg.sv
// Shared definitions for the colour frame detector: verdict codes, RGB332
// field positions and the per-channel limits that define the red and blue
// pixel classes, plus helpers that apply those limits to one pixel.
package color_det_pkg;

  typedef enum logic [2:0] {
    RES_NONE = 3'd0,
    RES_RED  = 3'd1,
    RES_BLUE = 3'd2
  } result_e;

  // RGB332 field positions
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  // Red class: strong red, weak green, weak blue
  localparam logic [2:0] RED_R_MIN  = 3'd5;
  localparam logic [2:0] RED_G_MAX  = 3'd2;
  localparam logic [1:0] RED_B_MAX  = 2'd1;

  // Blue class: full blue, weak red, modest green
  localparam logic [1:0] BLUE_B_VAL = 2'd3;
  localparam logic [2:0] BLUE_R_MAX = 3'd2;
  localparam logic [2:0] BLUE_G_MAX = 3'd3;

  function automatic logic px_is_red(input logic [7:0] p);
    return (p[R_MSB:R_LSB] >= RED_R_MIN) &&
           (p[G_MSB:G_LSB] <= RED_G_MAX) &&
           (p[B_MSB:B_LSB] <= RED_B_MAX);
  endfunction

  function automatic logic px_is_blue(input logic [7:0] p);
    return (p[B_MSB:B_LSB] == BLUE_B_VAL) &&
           (p[R_MSB:R_LSB] <= BLUE_R_MAX) &&
           (p[G_MSB:G_LSB] <= BLUE_G_MAX);
  endfunction

endpackage

// File: rtl/pixel_classifier.sv
// Decodes one pixel into red/blue class flags gated by valid and the ROI,
// and registers them together with the frame-end marker.
// Latency: 1 cycle. No backpressure: accepts a pixel every cycle.
// Ports: i_clk/i_rst (async active-high), i_pixel/i_valid/i_x/i_y pixel
//        beat, i_frame_end marker; o_is_red/o_is_blue/o_fe_d registered.
module pixel_classifier
  import color_det_pkg::*;
#(
  parameter int ROI_X0 = 0,
  parameter int ROI_X1 = 175,
  parameter int ROI_Y0 = 0,
  parameter int ROI_Y1 = 143
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_pixel,
  input  logic       i_valid,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_frame_end,
  output logic       o_is_red,
  output logic       o_is_blue,
  output logic       o_fe_d
);

  localparam logic [9:0] X0     = 10'(ROI_X0);
  localparam logic [9:0] Y0     = 10'(ROI_Y0);
  localparam logic [9:0] X_SPAN = 10'(ROI_X1 - ROI_X0);
  localparam logic [9:0] Y_SPAN = 10'(ROI_Y1 - ROI_Y0);

  logic [9:0] w_dx, w_dy;
  logic       w_in_roi, w_red, w_blue;
  logic       r_is_red, r_is_blue, r_fe_d;

  // Window test as one unsigned range check per axis: coordinates below the
  // lower bound wrap to large values and fall outside the span.
  assign w_dx     = i_x - X0;
  assign w_dy     = i_y - Y0;
  assign w_in_roi = (w_dx <= X_SPAN) && (w_dy <= Y_SPAN);

  assign w_red  = i_valid && w_in_roi && px_is_red(i_pixel);
  assign w_blue = i_valid && w_in_roi && px_is_blue(i_pixel);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_is_red  <= 1'b0;
      r_is_blue <= 1'b0;
      r_fe_d    <= 1'b0;
    end else begin
      r_is_red  <= w_red;
      r_is_blue <= w_blue;
      r_fe_d    <= i_frame_end;
    end
  end

  assign o_is_red  = r_is_red;
  assign o_is_blue = r_is_blue;
  assign o_fe_d    = r_fe_d;

endmodule

// File: rtl/color_frame_detector.sv
// Counts red/blue pixels inside the ROI per frame and issues a debounced
// verdict at each frame end.
// Latency: FRAME_END sampled at edge k -> RESULT/RESULT_VALID at edge k+3.
// No backpressure: pixel stream accepted every cycle, frame ends pipelined.
// Ports: CLK/RESET (async active-high); PIXEL_IN/PIXEL_VALID/PIXEL_X/PIXEL_Y
//        pixel beat; FRAME_END last-cycle pulse; RESULT verdict code,
//        RESULT_VALID per-frame pulse, RED_COUNT/BLUE_COUNT last frame counts.
module color_frame_detector
  import color_det_pkg::*;
#(
  parameter int ROI_X0        = 0,
  parameter int ROI_X1        = 175,
  parameter int ROI_Y0        = 0,
  parameter int ROI_Y1        = 143,
  parameter int RED_THRESH    = 1000,
  parameter int BLUE_THRESH   = 1000,
  parameter int STABLE_FRAMES = 2,
  parameter int COUNT_W       = 15
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [7:0]         PIXEL_IN,
  input  logic               PIXEL_VALID,
  input  logic [9:0]         PIXEL_X,
  input  logic [9:0]         PIXEL_Y,
  input  logic               FRAME_END,
  output logic [2:0]         RESULT,
  output logic               RESULT_VALID,
  output logic [COUNT_W-1:0] RED_COUNT,
  output logic [COUNT_W-1:0] BLUE_COUNT
);

  localparam int                 SW         = $clog2(STABLE_FRAMES + 1);
  localparam logic [COUNT_W-1:0] CNT_MAX    = '1;
  localparam logic [SW-1:0]      STABLE_MAX = SW'(STABLE_FRAMES);

  // Stage 1: registered class flags
  logic w_is_red, w_is_blue, w_fe_d;

  pixel_classifier #(
    .ROI_X0 (ROI_X0),
    .ROI_X1 (ROI_X1),
    .ROI_Y0 (ROI_Y0),
    .ROI_Y1 (ROI_Y1)
  ) u_classifier (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_pixel     (PIXEL_IN),
    .i_valid     (PIXEL_VALID),
    .i_x         (PIXEL_X),
    .i_y         (PIXEL_Y),
    .i_frame_end (FRAME_END),
    .o_is_red    (w_is_red),
    .o_is_blue   (w_is_blue),
    .o_fe_d      (w_fe_d)
  );

  // Stage 2: accumulators and frame snapshot
  logic [COUNT_W-1:0] r_red_acc, r_blue_acc;
  logic [COUNT_W-1:0] r_red_snap, r_blue_snap;
  logic [COUNT_W-1:0] w_red_sum, w_blue_sum;
  logic               r_snap_vld;

  always_comb begin
    w_red_sum  = (r_red_acc  == CNT_MAX) ? CNT_MAX : r_red_acc  + COUNT_W'(w_is_red);
    w_blue_sum = (r_blue_acc == CNT_MAX) ? CNT_MAX : r_blue_acc + COUNT_W'(w_is_blue);
  end

  // On the frame-end beat the sum (including that beat's pixel) goes to the
  // snapshot and the accumulators restart at zero, so the very next pixel
  // already belongs to the new frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_red_acc   <= '0;
      r_blue_acc  <= '0;
      r_red_snap  <= '0;
      r_blue_snap <= '0;
      r_snap_vld  <= 1'b0;
    end else begin
      r_snap_vld <= w_fe_d;
      if (w_fe_d) begin
        r_red_snap  <= w_red_sum;
        r_blue_snap <= w_blue_sum;
        r_red_acc   <= '0;
        r_blue_acc  <= '0;
      end else begin
        r_red_acc  <= w_red_sum;
        r_blue_acc <= w_blue_sum;
      end
    end
  end

  // EVAL: per-frame verdict; ties and sub-threshold counts give none
  result_e            w_verdict, r_verdict;
  logic               r_eval_vld;
  logic [COUNT_W-1:0] r_red_count, r_blue_count;

  always_comb begin
    w_verdict = RES_NONE;
    if ((32'(r_red_snap) >= 32'(RED_THRESH)) && (r_red_snap > r_blue_snap))
      w_verdict = RES_RED;
    else if ((32'(r_blue_snap) >= 32'(BLUE_THRESH)) && (r_blue_snap > r_red_snap))
      w_verdict = RES_BLUE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_verdict    <= RES_NONE;
      r_eval_vld   <= 1'b0;
      r_red_count  <= '0;
      r_blue_count <= '0;
    end else begin
      r_eval_vld <= r_snap_vld;
      if (r_snap_vld) begin
        r_verdict    <= w_verdict;
        r_red_count  <= r_red_snap;
        r_blue_count <= r_blue_snap;
      end
    end
  end

  // FILTER: RESULT only moves once the same verdict has been seen on
  // STABLE_FRAMES consecutive frames.
  result_e       r_cand, w_cand_next, r_result;
  logic [SW-1:0] r_stable, w_stable_next;
  logic          r_result_vld;

  always_comb begin
    w_cand_next   = r_cand;
    w_stable_next = r_stable;
    if (r_verdict == r_cand) begin
      if (r_stable < STABLE_MAX)
        w_stable_next = r_stable + SW'(1);
    end else begin
      w_cand_next   = r_verdict;
      w_stable_next = SW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cand       <= RES_NONE;
      r_stable     <= '0;
      r_result     <= RES_NONE;
      r_result_vld <= 1'b0;
    end else begin
      r_result_vld <= r_eval_vld;
      if (r_eval_vld) begin
        r_cand   <= w_cand_next;
        r_stable <= w_stable_next;
        if (w_stable_next >= STABLE_MAX)
          r_result <= w_cand_next;
      end
    end
  end

  assign RESULT       = r_result;
  assign RESULT_VALID = r_result_vld;
  assign RED_COUNT    = r_red_count;
  assign BLUE_COUNT   = r_blue_count;

endmodule

// File: tb/tb_color_frame_detector.sv
// Directed bench for color_frame_detector: a default instance, a small-ROI
// instance and a narrow-counter instance share one pixel stream; expected
// values are hand-computed per frame.
module tb_color_frame_detector;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] PIXEL_IN;
  logic       PIXEL_VALID;
  logic [9:0] PIXEL_X, PIXEL_Y;
  logic       FRAME_END;

  logic [2:0]  m_result, r_result, s_result;
  logic        m_vld, r_vld, s_vld;
  logic [14:0] m_red, m_blue, r_red, r_blue;
  logic [3:0]  s_red, s_blue;

  int n_tests = 0;
  int n_fail  = 0;
  int n_vld   = 0;
  int idx     = 0;

  always #5 CLK = ~CLK;

  color_frame_detector u_main (
    .CLK(CLK), .RESET(RESET), .PIXEL_IN(PIXEL_IN), .PIXEL_VALID(PIXEL_VALID),
    .PIXEL_X(PIXEL_X), .PIXEL_Y(PIXEL_Y), .FRAME_END(FRAME_END),
    .RESULT(m_result), .RESULT_VALID(m_vld), .RED_COUNT(m_red), .BLUE_COUNT(m_blue)
  );

  color_frame_detector #(.ROI_X0(10), .ROI_X1(19), .ROI_Y0(20), .ROI_Y1(29)) u_roi (
    .CLK(CLK), .RESET(RESET), .PIXEL_IN(PIXEL_IN), .PIXEL_VALID(PIXEL_VALID),
    .PIXEL_X(PIXEL_X), .PIXEL_Y(PIXEL_Y), .FRAME_END(FRAME_END),
    .RESULT(r_result), .RESULT_VALID(r_vld), .RED_COUNT(r_red), .BLUE_COUNT(r_blue)
  );

  color_frame_detector #(.COUNT_W(4), .RED_THRESH(10), .BLUE_THRESH(10),
                         .STABLE_FRAMES(1)) u_sat (
    .CLK(CLK), .RESET(RESET), .PIXEL_IN(PIXEL_IN), .PIXEL_VALID(PIXEL_VALID),
    .PIXEL_X(PIXEL_X), .PIXEL_Y(PIXEL_Y), .FRAME_END(FRAME_END),
    .RESULT(s_result), .RESULT_VALID(s_vld), .RED_COUNT(s_red), .BLUE_COUNT(s_blue)
  );

  always @(negedge CLK) if (m_vld) n_vld++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] p, input logic v, input logic fe);
    @(negedge CLK);
    PIXEL_IN    = p;
    PIXEL_VALID = v;
    FRAME_END   = fe;
    PIXEL_X     = 10'(idx % 176);
    PIXEL_Y     = 10'((idx / 176) % 144);
    if (v) idx++;
  endtask

  task automatic send(input logic [7:0] p, input int n);
    for (int i = 0; i < n; i++) drive(p, 1'b1, 1'b0);
  endtask

  // FRAME_END beat (optionally carrying a pixel), then the first beat of the
  // next frame, then idle until the verdict pulse three edges later.
  task automatic close_frame(input logic [7:0] fe_p, input logic fe_v,
                             input logic [7:0] nx_p, input logic nx_v, input string tag);
    drive(fe_p, fe_v, 1'b1);
    idx = 0;
    drive(nx_p, nx_v, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    chk({tag, ".vld"}, 32'(m_vld), 32'd1);
    drive(8'h00, 1'b0, 1'b0);
    chk({tag, ".vld_low"}, 32'(m_vld), 32'd0);
  endtask

  task automatic end_frame(input string tag);
    close_frame(8'h00, 1'b0, 8'h00, 1'b0, tag);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET       = 1'b1;
    PIXEL_VALID = 1'b0;
    FRAME_END   = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    idx   = 0;
  endtask

  logic [7:0] cls_px [13];

  initial begin
    RESET = 1'b1; PIXEL_IN = '0; PIXEL_VALID = 1'b0; PIXEL_X = '0; PIXEL_Y = '0; FRAME_END = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst.result", 32'(m_result), 32'd0);
    chk("rst.vld",    32'(m_vld),    32'd0);
    chk("rst.red",    32'(m_red),    32'd0);
    chk("rst.blue",   32'(m_blue),   32'd0);
    RESET = 1'b0;

    // Reset in the middle of a frame discards the partial counts
    send(8'hE0, 500);
    do_reset();
    send(8'hE0, 1200);
    end_frame("rst_f1");
    chk("rst_f1.red",    32'(m_red),    32'd1200);
    chk("rst_f1.blue",   32'(m_blue),   32'd0);
    chk("rst_f1.result", 32'(m_result), 32'd0);
    send(8'hE0, 1200);
    end_frame("rst_f2");
    chk("rst_f2.result", 32'(m_result), 32'd1);

    // Debounce: red, red, blue, blue
    do_reset();
    n_vld = 0;
    send(8'hE0, 2000); end_frame("db_a");
    chk("db_a.red",    32'(m_red),    32'd2000);
    chk("db_a.result", 32'(m_result), 32'd0);
    send(8'hE0, 2000); end_frame("db_b");
    chk("db_b.result", 32'(m_result), 32'd1);
    send(8'h03, 2000); end_frame("db_c");
    chk("db_c.blue",   32'(m_blue),   32'd2000);
    chk("db_c.red",    32'(m_red),    32'd0);
    chk("db_c.result", 32'(m_result), 32'd1);
    send(8'h03, 2000); end_frame("db_d");
    chk("db_d.result", 32'(m_result), 32'd2);
    chk("db.pulses",   32'(n_vld),    32'd4);

    // Full frame of red: small-ROI instance counts only its 10x10 window
    send(8'hE0, 176 * 144); end_frame("roi");
    chk("roi.main_red", 32'(m_red),    32'd25344);
    chk("roi.win_red",  32'(r_red),    32'd100);
    chk("roi.win_blue", 32'(r_blue),   32'd0);
    chk("roi.result",   32'(m_result), 32'd2);

    // R=7,B=3 belongs to neither class
    send(8'hE3, 1000); end_frame("e3");
    chk("e3.red",  32'(m_red),  32'd0);
    chk("e3.blue", 32'(m_blue), 32'd0);

    // Per-channel class edges: 4 red, 2 blue, rest neither
    cls_px = '{8'hA0, 8'hA8, 8'hA1, 8'hE0, 8'hAC, 8'hA2, 8'h80,
               8'hE3, 8'h03, 8'h4F, 8'h53, 8'h63, 8'h02};
    for (int i = 0; i < 13; i++) send(cls_px[i], 1);
    end_frame("cls");
    chk("cls.red",    32'(m_red),    32'd4);
    chk("cls.blue",   32'(m_blue),   32'd2);
    chk("cls.result", 32'(m_result), 32'd0);

    // Thresholds and ties
    send(8'hE0, 999); end_frame("t999a");
    chk("t999a.red", 32'(m_red), 32'd999);
    send(8'hE0, 999); end_frame("t999b");
    chk("t999b.result", 32'(m_result), 32'd0);
    send(8'hE0, 1000); end_frame("t1000a");
    chk("t1000a.result", 32'(m_result), 32'd0);
    send(8'hE0, 1000); end_frame("t1000b");
    chk("t1000b.result", 32'(m_result), 32'd1);
    send(8'hE0, 1500); send(8'h03, 1500); end_frame("tie_a");
    chk("tie_a.red",    32'(m_red),    32'd1500);
    chk("tie_a.blue",   32'(m_blue),   32'd1500);
    chk("tie_a.result", 32'(m_result), 32'd1);
    send(8'hE0, 1500); send(8'h03, 1500); end_frame("tie_b");
    chk("tie_b.result", 32'(m_result), 32'd0);

    // Pixel on the FRAME_END beat closes the old frame; the next one opens the new
    send(8'hE0, 5);
    close_frame(8'hE0, 1'b1, 8'hE0, 1'b1, "bnd_a");
    chk("bnd_a.red", 32'(m_red), 32'd6);
    end_frame("bnd_b");
    chk("bnd_b.red", 32'(m_red), 32'd1);

    // Narrow counters saturate; single-frame debounce follows the verdict
    send(8'hE0, 30); end_frame("sat_a");
    chk("sat_a.main_red", 32'(m_red),    32'd30);
    chk("sat_a.sat_red",  32'(s_red),    32'd15);
    chk("sat_a.result",   32'(s_result), 32'd1);
    send(8'hE0, 14); end_frame("sat_b");
    chk("sat_b.sat_red",  32'(s_red),    32'd14);
    end_frame("sat_c");
    chk("sat_c.sat_red",  32'(s_red),    32'd0);
    chk("sat_c.result",   32'(s_result), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
